// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry block: FSM states, key codes
// and the row/column decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam int NUM_MAX = 8191;

    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    // Only meaningful for one-hot-low patterns; anything else maps to 0.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_decode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_decode = 4'd1;
            4'h1: key_decode = 4'd2;
            4'h2: key_decode = 4'd3;
            4'h3: key_decode = KEY_A;
            4'h4: key_decode = 4'd4;
            4'h5: key_decode = 4'd5;
            4'h6: key_decode = 4'd6;
            4'h7: key_decode = KEY_B;
            4'h8: key_decode = 4'd7;
            4'h9: key_decode = 4'd8;
            4'hA: key_decode = 4'd9;
            4'hB: key_decode = KEY_C;
            4'hC: key_decode = KEY_STAR;
            4'hD: key_decode = 4'd0;
            4'hE: key_decode = KEY_HASH;
            default: key_decode = KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_entry_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines; idles high
// to match the external pull-ups.
module col_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with press/release debounce that accumulates decimal
// digits into a 13-bit value for the display driver.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [12:0] num,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    col_s;
    state_t        state, state_next;
    logic [SW-1:0] scan_cnt, scan_cnt_next;
    logic [DW-1:0] db_cnt, db_cnt_next;
    logic [3:0]    col_latch, col_latch_next;
    logic [3:0]    row_next;
    logic [12:0]   num_next;
    logic          key_valid_next;
    logic [3:0]    key_code_next;
    logic [3:0]    accept_code;
    logic [16:0]   appended;

    col_sync u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            col_latch <= 4'hF;
            row       <= 4'b1110;
            num       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_next;
            scan_cnt  <= scan_cnt_next;
            db_cnt    <= db_cnt_next;
            col_latch <= col_latch_next;
            row       <= row_next;
            num       <= num_next;
            key_valid <= key_valid_next;
            key_code  <= key_code_next;
        end
    end

    // The row register stays put outside SCAN, so it doubles as the latched key row.
    assign accept_code = key_decode(low_index(row), low_index(col_latch));
    assign appended    = 17'(num) * 17'd10 + 17'(accept_code);

    always_comb begin
        state_next     = state;
        scan_cnt_next  = scan_cnt;
        db_cnt_next    = db_cnt;
        col_latch_next = col_latch;
        row_next       = row;
        num_next       = num;
        key_valid_next = 1'b0;
        key_code_next  = key_code;

        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_next = '0;
                    if (one_low(col_s)) begin
                        col_latch_next = col_s;
                        db_cnt_next    = '0;
                        state_next     = DEBOUNCE;
                    end else begin
                        row_next = {row[2:0], row[3]};
                    end
                end else begin
                    scan_cnt_next = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s != col_latch) begin
                    db_cnt_next = '0;
                    state_next  = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt_next    = '0;
                    state_next     = PRESSED;
                    key_valid_next = 1'b1;
                    key_code_next  = accept_code;
                    if (accept_code <= 4'd9) begin
                        if (appended <= 17'(NUM_MAX))
                            num_next = appended[12:0];
                    end else if (accept_code == KEY_STAR) begin
                        num_next = '0;
                    end else if (accept_code == KEY_HASH) begin
                        num_next = num / 13'd10;
                    end
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (col_s == 4'hF) begin
                    db_cnt_next = '0;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (col_s != 4'hF) begin
                    db_cnt_next = '0;
                    state_next  = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt_next = '0;
                    state_next  = SCAN;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

endmodule
